// File: rtl/jt49_pkg.sv
// jt49_pkg: shared widths, sequencer state encoding and log-volume table for the JT49 mixer
package jt49_pkg;
  localparam int LVL_W = 5;
  localparam int VOL_W = 8;
  localparam int SUM_W = 10;
  typedef enum logic [1:0] {CAP, CHA, CHB, CHC} state_t;
  // 1.5 dB per level step, full scale 255 at level 31, level 0 is silence
  localparam logic [VOL_W-1:0] VOL_LUT [32] = '{
    8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
    8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd11,  8'd14,  8'd16,
    8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
    8'd76,  8'd90,  8'd108, 8'd128, 8'd152, 8'd181, 8'd215, 8'd255
  };
endpackage

// File: rtl/jt49_vol_lut.sv
// jt49_vol_lut: combinational 5-bit level to 8-bit log volume lookup
module jt49_vol_lut
  import jt49_pkg::*;
(
  input  logic [LVL_W-1:0] level,
  output logic [VOL_W-1:0] vol
);
  assign vol = VOL_LUT[level];
endmodule

// File: rtl/jt49_chmix.sv
// jt49_chmix: JT49 channel mixer, one shared volume lookup time-multiplexed over a 4-step frame
// Optional per-channel volume ports ch_a/ch_b/ch_c are built when JT49_CH_OUT_EN is defined.
module jt49_chmix
  import jt49_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             tone_a,
  input  logic             tone_b,
  input  logic             tone_c,
  input  logic             noise,
  input  logic [5:0]       mix_n,
  input  logic [4:0]       amp_a,
  input  logic [4:0]       amp_b,
  input  logic [4:0]       amp_c,
  input  logic [4:0]       env,
  output logic [SUM_W-1:0] out,
  output logic             out_valid
`ifdef JT49_CH_OUT_EN
  ,
  output logic [VOL_W-1:0] ch_a,
  output logic [VOL_W-1:0] ch_b,
  output logic [VOL_W-1:0] ch_c
`endif
);
  function automatic logic [LVL_W-1:0] chan_level(
    input logic       tone,
    input logic       nz,
    input logic       tone_off,
    input logic       noise_off,
    input logic [4:0] amp,
    input logic [4:0] e
  );
    logic g;
    g = (tone | tone_off) & (nz | noise_off);
    return !g ? '0 : amp[4] ? e : (amp[3:0] == 4'd0) ? '0 : {amp[3:0], 1'b1};
  endfunction
  state_t state, state_nxt;
  logic [2:0] s_tone;
  logic s_noise;
  logic [5:0] s_mix;
  logic [4:0] s_amp_a, s_amp_b, s_amp_c, s_env;
  logic [SUM_W-1:0] acc;
  logic [LVL_W-1:0] level;
  logic [VOL_W-1:0] vol;
  always_comb begin
    state_nxt = cen ? state_t'(state + 2'd1) : state;
    level = state == CHA ? chan_level(s_tone[0], s_noise, s_mix[0], s_mix[3], s_amp_a, s_env) :
            state == CHB ? chan_level(s_tone[1], s_noise, s_mix[1], s_mix[4], s_amp_b, s_env) :
                           chan_level(s_tone[2], s_noise, s_mix[2], s_mix[5], s_amp_c, s_env);
  end
  jt49_vol_lut u_lut (.level(level), .vol(vol));
  always_ff @(posedge clk)
    if (!rst_n) state <= CAP;
    else state <= state_nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_tone <= '0;
      s_noise <= 1'b0;
      s_mix <= '0;
      s_amp_a <= '0;
      s_amp_b <= '0;
      s_amp_c <= '0;
      s_env <= '0;
      acc <= '0;
      out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= cen && state == CHC;
      if (cen && state == CAP) begin
        s_tone <= {tone_c, tone_b, tone_a};
        s_noise <= noise;
        s_mix <= mix_n;
        s_amp_a <= amp_a;
        s_amp_b <= amp_b;
        s_amp_c <= amp_c;
        s_env <= env;
        acc <= '0;
      end
      if (cen && (state == CHA || state == CHB)) acc <= acc + SUM_W'(vol);
      if (cen && state == CHC) out <= acc + SUM_W'(vol);
    end
  end
`ifdef JT49_CH_OUT_EN
  logic [VOL_W-1:0] hold_a, hold_b;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_a <= '0;
      hold_b <= '0;
      ch_a <= '0;
      ch_b <= '0;
      ch_c <= '0;
    end else begin
      if (cen && state == CHA) hold_a <= vol;
      if (cen && state == CHB) hold_b <= vol;
      if (cen && state == CHC) begin
        ch_a <= hold_a;
        ch_b <= hold_b;
        ch_c <= vol;
      end
    end
  end
`endif
endmodule

// File: doc/jt49_chmix.md
# jt49_chmix

Channel mixer and volume stage of the JT49 PSG core. It consumes the three tone square waves, the 17-bit LFSR noise bit and the envelope level, and applies the register-7 enables and per-channel amplitude registers. A single shared log-volume lookup is time-multiplexed over the three channels. It produces a coherent 10-bit summed output once per 4-step mixer frame.

## Interface

Parameters:
- none

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset: synchronous, active-low
- cen  in  1  mixer step enable; the sequencer advances only on clk edges with cen=1
- tone_a, tone_b, tone_c  in  1 each  tone generator outputs
- noise  in  1  noise generator output (LFSR bit 16)
- mix_n  in  6  register 7, active-low enables: [2:0] tone A/B/C, [5:3] noise A/B/C
- amp_a, amp_b, amp_c  in  5 each  amplitude registers: [4] envelope mode, [3:0] fixed level
- env  in  5  envelope generator level, 0..31
- out  out  10  summed channel volume, 0..765
- out_valid  out  1  one-clk pulse when out updates
- ch_a, ch_b, ch_c  out  8 each  per-channel volumes (only with JT49_CH_OUT_EN)

## Operation

- Gate per channel x: g = (tone_x | mix_n[x]) & (noise | mix_n[3+x]). A disabled source forces its term to 1.
- 5-bit level per channel:
  - envelope mode (amp[4]=1): env
  - fixed mode, amp[3:0]=0: 0
  - fixed mode, otherwise: {amp[3:0],1'b1}
- Gated level: g ? level : 0.
- Volume: LUT[level], 8-bit unsigned.
  - LUT[0]=0.
  - For n≥1: LUT[n]=round(255·10^(-(31-n)·1.5/20)). Anchor values: LUT[31]=255, LUT[30]=215, LUT[29]=181.
- Sequencer states, cycling CAP→CHA→CHB→CHC→CAP, each transition on a cen edge:
  - CAP: snapshot tone_a/b/c, noise, mix_n, amp_a/b/c and env into internal registers; acc←0.
  - CHA: acc←acc+LUT[A].
  - CHB: acc←acc+LUT[B].
  - CHC: out←acc+LUT[C]; the ch_x registers load; out_valid←1.
- All lookups in CHA..CHC use snapshot values only. Input changes after the CAP edge take effect in the next frame.
- Arithmetic: acc is 10 bits, unsigned. The maximum is 3·255=765, so there is no overflow and no saturation.

## Timing

- Reset values:
  - state=CAP
  - acc=0, out=0, out_valid=0
  - ch_a/b/c=0
  - all snapshot registers 0
- Reset asserted mid-frame discards the partial frame. After release, the first out_valid follows the 4th cen edge.
- Frame period: 4 cen edges. out and ch_x change only on the CHC edge.
- out_valid is high for exactly one clk cycle after the CHC edge, whether or not cen is high in that following cycle.
- Output latency: 3 cen edges from the snapshot (CAP edge) to out update.
- cen=0: state, acc, out and ch_x hold. out_valid stays 0 except for its single pulse.
- The core's cen for this block is a free-running divided enable. No back-pressure; a downstream consumer samples out on out_valid.

## Configuration

- JT49_CH_OUT_EN defined:
  - ports ch_a/ch_b/ch_c exist.
  - three 8-bit holding registers capture LUT[A] in CHA and LUT[B] in CHB; all three publish to ch_x on the CHC edge.
- JT49_CH_OUT_EN undefined:
  - ports and holding registers are absent.
  - out and out_valid behave identically.

## Structure

- Package jt49_pkg holds:
  - the 32×8 LUT constant
  - the sequencer state encoding (CAP, CHA, CHB, CHC; 2 bits)
  - width constants: level 5, volume 8, sum 10
- Sub-module jt49_vol_lut: combinational, 5-bit level in, 8-bit volume out, indexing the package constant. One instance is shared by all three slots through a snapshot mux selected by state.
- The gate and level decode is a function inside jt49_chmix.

## Test plan

1. Reset and start-up:
   - Stimulus: hold rst_n=0 for 10 clks with cen toggling; release.
   - Response: out=0, out_valid=0 and ch_x=0 while in reset; first out_valid only after the 4th cen edge following release.
2. All enables off with full fixed level:
   - Stimulus: mix_n=6'h3F, amp_a=amp_b=amp_c=5'h0F.
   - Response: out=765, ch_a=ch_b=ch_c=255.
3. Tone gating on channel A:
   - Stimulus: mix_n=6'b111110, amp_a=5'h0F, other amps 0.
   - Response: tone_a=0 gives out=0; tone_a=1 gives out=255.
4. Envelope mode on channel B:
   - Stimulus: amp_b=5'h10, env=30, mix_n=6'h3F, other amps 0.
   - Response: out=215, ch_b=215.
5. Snapshot coherence:
   - Stimulus: amp_a=5'h0F; change amp_a to 0 one clk after the CAP edge.
   - Response: current frame out=255; next frame out=0.
6. Stall and mid-frame reset:
   - Stimulus: hold cen=0 for 20 clks mid-frame; then apply rst_n=0 after the CHB edge.
   - Response: during the stall out is held and out_valid=0. After the reset, out=0 and the next out_valid arrives exactly 4 cen edges after release.
